data_memory_ctrl: RTL and testbench

- Parametrised, clocked successor to the combinational byte-array data memory used by the RISC-V pipeline's MEM stage.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns a held response.
- Byte order is little-endian for both loads and stores. Misaligned, out-of-range and illegal-size accesses are flagged instead of silently executed.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/data_memory_ctrl_if.sv | 27 ++
 rtl/dmem_byte_bank.sv | 46 ++++
 rtl/data_memory_ctrl.sv | 176 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the clocked data memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Number of bytes touched by an access; the illegal size is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Byte-lane enables for a store starting at lane 0 of the bank word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001;
            SZ_HALF: lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a MEM-stage master and the data memory controller.
interface data_memory_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sign_ext;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_sign_ext, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sign_ext, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_byte_bank.sv
// Byte-addressed storage: four little-endian lanes starting at a base address,
// synchronous write, combinational read. Lanes past the end read as zero.
module dmem_byte_bank #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH_BYTES = 512
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int unsigned EXT_W = ADDR_W + 2;
    localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    logic [7:0]       mem [DEPTH_BYTES];
    logic [EXT_W-1:0] lane_addr [4];
    logic [3:0]       lane_ok;

    // Per-lane byte address, widened so the end-of-array test cannot wrap.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            lane_addr[i] = {2'b00, addr} + EXT_W'(i);
            lane_ok[i]   = lane_addr[i] < EXT_W'(DEPTH_BYTES);
        end
    end

    // Commit enabled lanes on the rising edge; memory is never reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i] && lane_ok[i]) begin
                mem[lane_addr[i][IDX_W-1:0]] <= wdata[8*i +: 8];
            end
        end
    end

    // Little-endian read assembly.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lane_ok[i]) begin
                rdata[8*i +: 8] = mem[lane_addr[i][IDX_W-1:0]];
            end
        end
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// Clocked data memory controller: one request at a time, WAIT_STATES wait
// cycles, held response, alignment/range checking and load extension.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH_BYTES = 512,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    data_memory_ctrl_if.slave bus
);
    localparam int unsigned EXT_W     = ADDR_W + 2;
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            state, state_nxt;
    logic [3:0]        wait_cnt;
    logic              accept, enter_resp;

    logic              lat_we, lat_sext;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              cur_we, cur_sext, cur_err;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [EXT_W-1:0]  last_byte;
    logic              align_err;

    logic [3:0]        lane_en;
    logic [DATA_W-1:0] bank_rdata, load_data;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    // With zero wait states the commit edge is the acceptance edge, so the
    // live request is used in IDLE and the latched copy afterwards.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_we    = bus.req_we;
            cur_sext  = bus.req_sign_ext;
            cur_size  = bus.req_size;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_we    = lat_we;
            cur_sext  = lat_sext;
            cur_size  = lat_size;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    // Alignment, illegal-size and range check on the effective request.
    always_comb begin
        last_byte = {2'b00, cur_addr} + EXT_W'(size_bytes(cur_size)) - EXT_W'(1);
        case (cur_size)
            SZ_BYTE: align_err = 1'b0;
            SZ_HALF: align_err = cur_addr[0];
            SZ_WORD: align_err = |cur_addr[1:0];
            default: align_err = 1'b1;
        endcase
        cur_err = align_err || (last_byte >= EXT_W'(DEPTH_BYTES));
    end

    // Next-state, handshake outputs and the commit strobe.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept        = 1'b0;
        enter_resp    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = rst_n;
                if (rst_n && bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt  = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt  = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait-state counter, restarted on every acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Capture the request so later changes on the bus are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_sext  <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= bus.req_we;
            lat_sext  <= bus.req_sign_ext;
            lat_size  <= bus.req_size;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    // Zero/sign extension of the little-endian read data.
    always_comb begin
        case (cur_size)
            SZ_BYTE: load_data = {{24{cur_sext & bank_rdata[7]}}, bank_rdata[7:0]};
            SZ_HALF: load_data = {{16{cur_sext & bank_rdata[15]}}, bank_rdata[15:0]};
            default: load_data = bank_rdata;
        endcase
        lane_en = (enter_resp && cur_we && !cur_err) ? lane_mask(cur_size) : 4'b0000;
    end

    // Response registers, loaded on the edge entering RESP and held there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err_q   <= cur_err;
            rsp_rdata_q <= (cur_err || cur_we) ? '0 : load_data;
        end
    end

    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    dmem_byte_bank #(
        .ADDR_W      (ADDR_W),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_bank (
        .clk   (clk),
        .we    (lane_en),
        .addr  (cur_addr),
        .wdata (cur_wdata),
        .rdata (bank_rdata)
    );
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: two instances (no wait states /
// 512 bytes, and 3 wait states / 256 bytes) share one driver via a select.
`timescale 1ns/1ps
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        req_valid, req_we, req_sext, rsp_ready;
    logic [1:0]  req_size;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    int unsigned checks = 0;
    int unsigned errors = 0;

    data_memory_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b0 ();
    data_memory_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b1 ();

    data_memory_ctrl #(.ADDR_W(9), .DEPTH_BYTES(512), .WAIT_STATES(0), .DATA_W(32))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    data_memory_ctrl #(.ADDR_W(9), .DEPTH_BYTES(256), .WAIT_STATES(3), .DATA_W(32))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    assign b0.req_valid    = req_valid & ~sel;
    assign b1.req_valid    = req_valid & sel;
    assign b0.rsp_ready    = rsp_ready & ~sel;
    assign b1.rsp_ready    = rsp_ready & sel;
    assign b0.req_we       = req_we;
    assign b1.req_we       = req_we;
    assign b0.req_size     = req_size;
    assign b1.req_size     = req_size;
    assign b0.req_sign_ext = req_sext;
    assign b1.req_sign_ext = req_sext;
    assign b0.req_addr     = req_addr;
    assign b1.req_addr     = req_addr;
    assign b0.req_wdata    = req_wdata;
    assign b1.req_wdata    = req_wdata;

    assign req_ready_m = sel ? b1.req_ready : b0.req_ready;
    assign rsp_valid_m = sel ? b1.rsp_valid : b0.rsp_valid;
    assign rsp_rdata_m = sel ? b1.rsp_rdata : b0.rsp_rdata;
    assign rsp_err_m   = sel ? b1.rsp_err   : b0.rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] mdl [2][512];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (dut%0d, t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    // Reference behaviour: byte array, little-endian, extension by arithmetic.
    function automatic rsp_t model_access(input int s, input bit we, input int size,
                                          input bit sext, input int addr, input logic [31:0] wdata);
        rsp_t        r;
        int          n, depth;
        logic [31:0] v, t;
        depth   = (s == 0) ? 512 : 256;
        n       = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        r.rdata = 32'd0;
        r.err   = (size == 3) || (addr % n != 0) || (addr + n > depth);
        if (!r.err) begin
            if (we) begin
                for (int i = 0; i < n; i++) begin
                    t = wdata >> (8 * i);
                    mdl[s][addr + i] = t[7:0];
                end
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[s][addr + i]) << (8 * i));
                if (sext && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                r.rdata = v;
            end
        end
        return r;
    endfunction

    // Monitor: every cycle a response is presented it must match the oldest
    // expected entry; the entry retires when the consumer takes it.
    always @(negedge clk) begin
        if (rst_n && rsp_valid_m) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                check("rsp_rdata", rsp_rdata_m, exp_q[0].rdata);
                check("rsp_err", 32'(rsp_err_m), 32'(exp_q[0].err));
                check("req_ready_in_resp", 32'(req_ready_m), 32'd0);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One full transaction on the selected instance; hold = extra cycles of backpressure.
    task automatic issue(input bit we, input int size, input bit sext, input int addr,
                         input logic [31:0] wdata, input int hold);
        int   waits, lat, w;
        bit   seen;
        rsp_t r;
        w         = sel ? 3 : 0;
        req_we    = we;
        req_size  = 2'(size);
        req_sext  = sext;
        req_addr  = 9'(addr);
        req_wdata = wdata;
        req_valid = 1'b1;
        waits     = 0;
        @(negedge clk);
        while (!req_ready_m && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        check("req_ready_wait", 32'(waits), 32'd0);
        if (!req_ready_m) begin
            req_valid = 1'b0;
            return;
        end
        r = model_access(sel ? 1 : 0, we, size, sext, addr, wdata);
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_size  = 2'($urandom);
        req_sext  = 1'($urandom);
        req_addr  = 9'($urandom);
        req_wdata = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = rsp_valid_m;
            if (!seen) check("req_ready_in_wait", 32'(req_ready_m), 32'd0);
        end
        check("rsp_latency", 32'(lat), 32'(w + 1));
        if (!seen) begin
            void'(exp_q.pop_front());
            return;
        end
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int depth, sz, n, a;
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sext  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #12;
        check("rst_req_ready0", 32'(b0.req_ready), 32'd0);
        check("rst_rsp_valid0", 32'(b0.rsp_valid), 32'd0);
        check("rst_rsp_rdata0", b0.rsp_rdata, 32'd0);
        check("rst_rsp_err0", 32'(b0.rsp_err), 32'd0);
        check("rst_req_ready1", 32'(b1.req_ready), 32'd0);
        check("rst_rsp_valid1", 32'(b1.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill both memories so every later load has defined contents.
        for (int s = 0; s < 2; s++) begin
            sel   = 1'(s);
            depth = (s == 0) ? 512 : 256;
            for (int ad = 0; ad < depth; ad += 4) issue(1'b1, 2, 1'b0, ad, $urandom | 32'h0101_0101, 0);
        end

        sel = 1'b0;
        issue(1'b1, 2, 1'b0, 'h010, 32'hDEADBEEF, 0);
        issue(1'b0, 2, 1'b0, 'h010, 32'h0, 0);
        issue(1'b0, 0, 1'b0, 'h010, 32'h0, 0);
        issue(1'b1, 1, 1'b0, 'h020, 32'h1234_80F0, 0);
        issue(1'b0, 1, 1'b1, 'h020, 32'h0, 0);
        issue(1'b0, 1, 1'b0, 'h020, 32'h0, 0);
        issue(1'b0, 0, 1'b1, 'h021, 32'h0, 0);
        issue(1'b1, 2, 1'b0, 'h031, 32'h11223344, 0);
        issue(1'b0, 2, 1'b0, 'h030, 32'h0, 0);
        issue(1'b0, 3, 1'b0, 'h010, 32'h0, 0);
        issue(1'b1, 3, 1'b0, 'h010, 32'h5555_5555, 0);
        issue(1'b0, 2, 1'b0, 'h010, 32'h0, 0);
        issue(1'b0, 2, 1'b0, 'h1FC, 32'h0, 0);
        issue(1'b0, 1, 1'b1, 'h1FE, 32'h0, 0);
        issue(1'b0, 2, 1'b0, 'h1FD, 32'h0, 0);
        issue(1'b0, 0, 1'b1, 'h1FF, 32'h0, 0);

        sel = 1'b1;
        issue(1'b0, 2, 1'b0, 'h100, 32'h0, 0);
        issue(1'b0, 2, 1'b0, 'h0FC, 32'h0, 0);
        issue(1'b0, 1, 1'b0, 'h0FF, 32'h0, 0);
        issue(1'b0, 1, 1'b1, 'h0FE, 32'h0, 0);
        issue(1'b1, 0, 1'b0, 'h0FF, 32'h0000_0080, 5);
        issue(1'b0, 0, 1'b1, 'h0FF, 32'h0, 5);

        for (int s = 0; s < 2; s++) begin
            sel   = 1'(s);
            depth = (s == 0) ? 512 : 256;
            for (int k = 0; k < 80; k++) begin
                sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
                n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
                if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 511);
                else a = $urandom_range(0, depth - 1) & ~(n - 1);
                issue(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3));
            end
        end

        // Reset while a store sits in WAIT: it must never commit.
        sel = 1'b1;
        issue(1'b0, 2, 1'b0, 'h040, 32'h0, 0);
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_sext  = 1'b0;
        req_addr  = 9'h040;
        req_wdata = 32'hAAAA_AAAA;
        req_valid = 1'b1;
        @(negedge clk);
        check("midrst_accept_ready", 32'(req_ready_m), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_wait", 32'(rsp_valid_m), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid_m), 32'd0);
        check("midrst_req_ready", 32'(req_ready_m), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata_m, 32'd0);
        check("midrst_rsp_err", 32'(rsp_err_m), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 2, 1'b0, 'h040, 32'h0, 0);
        issue(1'b0, 2, 1'b0, 'h040, 32'h0, 2);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
